// File: rtl/clk_set_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_set_pkg
//  Purpose  : Shared mode encodings, FSM state type and counter width helper
//             for the clock time-setting controller.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package clk_set_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_SEC  = 2'd3;

  // State encoding equals the mode output encoding, so the state register
  // drives the mode output directly.
  typedef enum logic [1:0] {
    ST_RUN      = MODE_RUN,
    ST_SET_HOUR = MODE_SET_HOUR,
    ST_SET_MIN  = MODE_SET_MIN,
    ST_SET_SEC  = MODE_SET_SEC
  } state_e;

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_set_ctrl_if
//  Purpose  : Bundles the raw buttons and the timebase/set outputs of the
//             clock time-setting controller.
//  Signals  : btn_mode, btn_set          raw push-buttons (to controller)
//             en1hz, clr_sec, inc_min,
//             inc_hour                   single-cycle pulses (from controller)
//             mode[1:0], blink           display state (from controller)
//  Modports : master - the controller; slave - buttons/counter chain side
//  Revision : 1.0 - initial release
// ============================================================================
interface clk_set_ctrl_if;
  logic       btn_mode;
  logic       btn_set;
  logic       en1hz;
  logic       clr_sec;
  logic       inc_min;
  logic       inc_hour;
  logic [1:0] mode;
  logic       blink;

  modport master (
    input  btn_mode, btn_set,
    output en1hz, clr_sec, inc_min, inc_hour, mode, blink
  );

  modport slave (
    output btn_mode, btn_set,
    input  en1hz, clr_sec, inc_min, inc_hour, mode, blink
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : 2-FF synchroniser, debounce counter and rising-edge detector
//             for one raw push-button.
//  Ports    : clk    in  system clock
//             rst    in  asynchronous reset, active-high
//             btn    in  raw button, asynchronous to clk
//             level  out debounced level
//             press  out 1-cycle pulse, registered, after level goes 0->1
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import clk_set_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn,
  output logic      level,
  output logic      press
);

  localparam int              DB_W    = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync_a;
  logic            sync_b;
  logic            level_d;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      // db_cnt counts consecutive samples that disagree with the accepted
      // level; the DB_CYCLES-th such sample flips the level.
      if (sync_b != level) begin
        if (db_cnt == DB_LAST) begin
          level  <= sync_b;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_set_ctrl
//  Purpose  : Timebase and time-setting controller at the head of the clock
//             counter chain: 1 Hz enable, set-button pulses with auto-repeat,
//             mode FSM and display blink phase.
//  Ports    : clk   in  system clock
//             rst   in  asynchronous reset, active-high
//             bus   clk_set_ctrl_if.master
//                   (btn_mode/btn_set in; en1hz, clr_sec, inc_min, inc_hour,
//                    mode[1:0], blink out)
//  Revision : 1.0 - initial release
// ============================================================================
module clk_set_ctrl
  import clk_set_pkg::*;
#(
  parameter int SEC_CYCLES = 50_000_000,
  parameter int DB_CYCLES  = 1_000_000,
  parameter int REP_DELAY  = 25_000_000,
  parameter int REP_PERIOD = 5_000_000
) (
  input wire logic       clk,
  input wire logic       rst,
  clk_set_ctrl_if.master bus
);

  localparam int                SEC_W       = cnt_width(SEC_CYCLES);
  localparam logic [SEC_W-1:0]  SEC_LAST    = SEC_W'(SEC_CYCLES - 1);
  localparam logic [SEC_W-1:0]  SEC_PRE     = SEC_W'(SEC_CYCLES - 2);
  localparam int                HALF_W      = cnt_width(SEC_CYCLES / 2);
  localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(SEC_CYCLES / 2 - 1);
  localparam int                REP_W       = cnt_width((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD);
  localparam logic [REP_W-1:0]  DELAY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0]  PERIOD_LAST = REP_W'(REP_PERIOD - 1);

  state_e            state;
  state_e            state_nx;
  logic              mode_press;
  logic              mode_level_unused;
  logic              set_press;
  logic              set_level;
  logic [SEC_W-1:0]  psc;
  logic [HALF_W-1:0] blink_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              rep_armed;
  logic              rep_phase;   // 0: waiting REP_DELAY, 1: REP_PERIOD cadence
  logic              en1hz_q;
  logic              inc_hour_q;
  logic              inc_min_q;
  logic              clr_sec_q;
  logic              blink_q;

  logic              set_ok;
  logic              rep_fire;
  logic              en1hz_nx;
  logic              inc_hour_nx;
  logic              inc_min_nx;
  logic              clr_sec_nx;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_mode),
    .level (mode_level_unused),
    .press (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_set),
    .level (set_level),
    .press (set_press)
  );

  // Next state and next values of the registered output pulses.
  always_comb begin
    state_nx    = state;
    set_ok      = set_press & ~mode_press;   // a coincident mode press wins
    rep_fire    = 1'b0;
    en1hz_nx    = 1'b0;
    inc_hour_nx = 1'b0;
    inc_min_nx  = 1'b0;
    clr_sec_nx  = 1'b0;

    if (mode_press) begin
      case (state)
        ST_RUN:      state_nx = ST_SET_HOUR;
        ST_SET_HOUR: state_nx = ST_SET_MIN;
        ST_SET_MIN:  state_nx = ST_SET_SEC;
        ST_SET_SEC:  state_nx = ST_RUN;
        default:     state_nx = ST_RUN;
      endcase
    end

    if (rep_armed && set_level && !mode_press) begin
      rep_fire = rep_phase ? (rep_cnt == PERIOD_LAST) : (rep_cnt == DELAY_LAST);
    end

    case (state)
      // Registered one cycle early so en1hz is high while psc == SEC_LAST.
      ST_RUN:      en1hz_nx    = !mode_press && (psc == SEC_PRE);
      ST_SET_HOUR: inc_hour_nx = set_ok | rep_fire;
      ST_SET_MIN:  inc_min_nx  = set_ok | rep_fire;
      ST_SET_SEC:  clr_sec_nx  = set_ok;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en1hz_q    <= 1'b0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_sec_q  <= 1'b0;
    end else begin
      en1hz_q    <= en1hz_nx;
      inc_hour_q <= inc_hour_nx;
      inc_min_q  <= inc_min_nx;
      clr_sec_q  <= clr_sec_nx;
    end
  end

  // Prescaler runs only while staying in RUN; any SET state parks it at 0 so
  // the first second after returning to RUN is a full SEC_CYCLES long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc <= '0;
    end else if (state == ST_RUN && !mode_press) begin
      psc <= (psc == SEC_LAST) ? '0 : psc + 1'b1;
    end else begin
      psc <= '0;
    end
  end

  // Blink phase restarts at 0 on entry to SET_HOUR and is held at 0 in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (state == ST_RUN || state_nx == ST_RUN) begin
      blink_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (blink_cnt == HALF_LAST) begin
      blink_q   <= ~blink_q;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Auto-repeat timer. Only a fresh press in SET_HOUR/SET_MIN arms it; a
  // release or any mode change disarms it until the next press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_armed <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (mode_press || !set_level) begin
      rep_armed <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (set_ok && (state == ST_SET_HOUR || state == ST_SET_MIN)) begin
      rep_armed <= 1'b1;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_fire) begin
      rep_phase <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_armed) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign bus.mode     = state;
  assign bus.en1hz    = en1hz_q;
  assign bus.inc_hour = inc_hour_q;
  assign bus.inc_min  = inc_min_q;
  assign bus.clr_sec  = clr_sec_q;
  assign bus.blink    = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_set_ctrl
//  Purpose  : Directed self-checking bench for clk_set_ctrl with
//             SEC_CYCLES=10, DB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5.
//             A raw button raised just after edge 0 yields a press pulse
//             after edge 7 and a registered effect after edge 8.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   entry_cyc = 0;

  clk_set_ctrl_if bus ();

  clk_set_ctrl #(
    .SEC_CYCLES (10),
    .DB_CYCLES  (4),
    .REP_DELAY  (20),
    .REP_PERIOD (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one clean mode press; mode changes after the 8th tick.
  task automatic pulse_mode_btn();
    bus.btn_mode = 1'b1;
    repeat (10) tick();
    bus.btn_mode = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    bus.btn_mode = 1'b0;
    bus.btn_set  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if (bus.mode !== 2'd0) begin
      fails++; $display("FAIL reset_mode got %0d exp 0", bus.mode);
    end
    tests++;
    if ({bus.en1hz, bus.clr_sec, bus.inc_min, bus.inc_hour, bus.blink} !== 5'b0) begin
      fails++; $display("FAIL reset_outputs got %b exp 00000",
                        {bus.en1hz, bus.clr_sec, bus.inc_min, bus.inc_hour, bus.blink});
    end
    rst = 1'b0;
  endtask

  task automatic test_run_1hz();
    int n;
    logic exp;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = ((i % 10) == 9);
      tests++;
      if (bus.en1hz !== exp) begin
        fails++; $display("FAIL run_en1hz tick %0d got %b exp %b", i, bus.en1hz, exp);
      end
      if (bus.en1hz === 1'b1) n++;
    end
    tests++;
    if (n !== 3) begin
      fails++; $display("FAIL run_en1hz_count got %0d exp 3", n);
    end
    tests++;
    if (bus.mode !== 2'd0 || bus.blink !== 1'b0) begin
      fails++; $display("FAIL run_mode_blink got mode %0d blink %b exp 0 0", bus.mode, bus.blink);
    end
  endtask

  task automatic test_mode_glitch();
    logic [1:0] exp;
    bus.btn_mode = 1'b1;
    repeat (3) tick();
    bus.btn_mode = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      tests++;
      if (bus.mode !== 2'd0) begin
        fails++; $display("FAIL glitch_mode tick %0d got %0d exp 0", i, bus.mode);
      end
    end
    bus.btn_mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = (i >= 8) ? 2'd1 : 2'd0;
      tests++;
      if (bus.mode !== exp) begin
        fails++; $display("FAIL hold_mode tick %0d got %0d exp %0d", i, bus.mode, exp);
      end
      if (i == 8) entry_cyc = cyc;
    end
    bus.btn_mode = 1'b0;
    repeat (10) tick();
    tests++;
    if (bus.mode !== 2'd1) begin
      fails++; $display("FAIL release_mode got %0d exp 1", bus.mode);
    end
  endtask

  task automatic test_set_hour();
    int   n;
    logic exp_b;
    n = 0;
    bus.btn_set = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_b = ((((cyc - entry_cyc) / 5) % 2) == 1);
      tests++;
      if (bus.inc_hour !== (i == 8)) begin
        fails++; $display("FAIL set_hour_inc tick %0d got %b exp %b", i, bus.inc_hour, (i == 8));
      end
      tests++;
      if ({bus.en1hz, bus.inc_min, bus.clr_sec} !== 3'b0) begin
        fails++; $display("FAIL set_hour_other tick %0d got %b exp 000", i,
                          {bus.en1hz, bus.inc_min, bus.clr_sec});
      end
      tests++;
      if (bus.blink !== exp_b) begin
        fails++; $display("FAIL set_hour_blink tick %0d got %b exp %b", i, bus.blink, exp_b);
      end
      if (bus.inc_hour === 1'b1) n++;
      if (i == 8) bus.btn_set = 1'b0;
    end
    tests++;
    if (n !== 1) begin
      fails++; $display("FAIL set_hour_count got %0d exp 1", n);
    end
  endtask

  task automatic test_set_min_repeat();
    int   n;
    logic exp;
    n = 0;
    pulse_mode_btn();
    tests++;
    if (bus.mode !== 2'd2) begin
      fails++; $display("FAIL enter_set_min got %0d exp 2", bus.mode);
    end
    bus.btn_set = 1'b1;
    for (int i = 1; i <= 62; i++) begin
      tick();
      exp = (i == 8) || (i == 28) || (i == 33) || (i == 38) || (i == 43) || (i == 48);
      tests++;
      if (bus.inc_min !== exp) begin
        fails++; $display("FAIL repeat_inc_min tick %0d got %b exp %b", i, bus.inc_min, exp);
      end
      tests++;
      if ({bus.en1hz, bus.inc_hour, bus.clr_sec} !== 3'b0) begin
        fails++; $display("FAIL repeat_other tick %0d got %b exp 000", i,
                          {bus.en1hz, bus.inc_hour, bus.clr_sec});
      end
      if (bus.inc_min === 1'b1) n++;
      if (i == 44) bus.btn_set = 1'b0;
    end
    tests++;
    if (n !== 6) begin
      fails++; $display("FAIL repeat_count got %0d exp 6", n);
    end
  endtask

  task automatic test_set_sec();
    int         n;
    logic [1:0] exp_m;
    n = 0;
    pulse_mode_btn();
    tests++;
    if (bus.mode !== 2'd3) begin
      fails++; $display("FAIL enter_set_sec got %0d exp 3", bus.mode);
    end
    bus.btn_set = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      tests++;
      if (bus.clr_sec !== (i == 8)) begin
        fails++; $display("FAIL set_sec_clr tick %0d got %b exp %b", i, bus.clr_sec, (i == 8));
      end
      tests++;
      if ({bus.en1hz, bus.inc_hour, bus.inc_min} !== 3'b0) begin
        fails++; $display("FAIL set_sec_other tick %0d got %b exp 000", i,
                          {bus.en1hz, bus.inc_hour, bus.inc_min});
      end
      if (bus.clr_sec === 1'b1) n++;
      if (i == 48) bus.btn_set = 1'b0;
    end
    tests++;
    if (n !== 1) begin
      fails++; $display("FAIL set_sec_count got %0d exp 1", n);
    end
    bus.btn_mode = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_m = (i >= 8) ? 2'd0 : 2'd3;
      tests++;
      if (bus.mode !== exp_m) begin
        fails++; $display("FAIL back_to_run tick %0d got %0d exp %0d", i, bus.mode, exp_m);
      end
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 2) bus.btn_mode = 1'b0;
      tests++;
      if (bus.en1hz !== ((k % 10) == 9)) begin
        fails++; $display("FAIL rerun_en1hz tick %0d got %b exp %b", k, bus.en1hz, ((k % 10) == 9));
      end
      tests++;
      if (bus.blink !== 1'b0 || bus.mode !== 2'd0) begin
        fails++; $display("FAIL rerun_state tick %0d got blink %b mode %0d exp 0 0", k, bus.blink, bus.mode);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_m;
    pulse_mode_btn();
    tests++;
    if (bus.mode !== 2'd1) begin
      fails++; $display("FAIL enter_set_hour got %0d exp 1", bus.mode);
    end
    bus.btn_mode = 1'b1;
    bus.btn_set  = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp_m = (i >= 8) ? 2'd2 : 2'd1;
      tests++;
      if (bus.mode !== exp_m) begin
        fails++; $display("FAIL simul_mode tick %0d got %0d exp %0d", i, bus.mode, exp_m);
      end
      tests++;
      if ({bus.inc_hour, bus.inc_min} !== 2'b00) begin
        fails++; $display("FAIL simul_inc tick %0d got %b exp 00", i, {bus.inc_hour, bus.inc_min});
      end
    end
    // Reset mid-hold, between clock edges: must clear at once.
    rst = 1'b1;
    #2;
    tests++;
    if (bus.mode !== 2'd0) begin
      fails++; $display("FAIL async_reset_mode got %0d exp 0", bus.mode);
    end
    tests++;
    if ({bus.en1hz, bus.clr_sec, bus.inc_min, bus.inc_hour, bus.blink} !== 5'b0) begin
      fails++; $display("FAIL async_reset_outputs got %b exp 00000",
                        {bus.en1hz, bus.clr_sec, bus.inc_min, bus.inc_hour, bus.blink});
    end
  endtask

  task automatic test_held_through_reset();
    logic [1:0] exp_m;
    bus.btn_set = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      exp_m = (i >= 8) ? 2'd1 : 2'd0;
      tests++;
      if (bus.mode !== exp_m) begin
        fails++; $display("FAIL held_reset_mode tick %0d got %0d exp %0d", i, bus.mode, exp_m);
      end
    end
    bus.btn_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_1hz();
    test_mode_glitch();
    test_set_hour();
    test_set_min_repeat();
    test_set_sec();
    test_simultaneous();
    test_held_through_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
